irq_arbiter: RTL

- Collects NUM_SRC asynchronous interrupt sources (buttons, switches, UART, timers) into pending bits.
- Masks and prioritises them, then drives the core's single level-sensitive irq/irq_id pair.
- Clears the served source on the core's irq_ack/irq_ack_id handshake.
- Sits between SoC peripherals and the processor interrupt port at system level.

---
 rtl/irq_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronises and edge-detects NUM_SRC sources into pending bits,
// masks and prioritises them, and drives a level irq/irq_id with ack handshake.
// Optional macro IRQ_ARB_ROUND_ROBIN_EN selects rotating priority instead of fixed lowest-index.
//
//   state  | meaning
//   IDLE   | no request outstanding, arbitrate among masked pending sources
//   ASSERT | irq/irq_id held for the latched winner until a matching ack
//   GAP    | one cycle with irq low so the core sees a deasserted level
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_BASE = 16
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask_q,
  output logic [NUM_SRC-1:0] pending_q,
  output logic               irq,
  output logic [4:0]         irq_id,
  input  logic               irq_ack,
  input  logic [4:0]         irq_ack_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [4:0] ID_BASE5 = 5'(ID_BASE);

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, hist_q;
  logic [NUM_SRC-1:0] pend_q, pend_d, mask_r;
  logic [NUM_SRC-1:0] edge_det, cand, clr;
  logic [4:0]         win_q, win_d, id_q, id_d, sel;
  logic               irq_q, irq_d, found, ack_ok;

  assign edge_det = sync2_q & ~hist_q;
  assign cand     = pend_q & mask_r;
  assign ack_ok   = (state_q == ASSERT) && irq_ack && (irq_ack_id == id_q);

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = ack_ok && (win_q == 5'(i));
    end
  end

  // A fresh edge on the served source beats the ack clear.
  assign pend_d = (pend_q & ~clr) | edge_det;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [4:0] ptr_q;

  always_ff @(posedge clk) begin
    if (res) begin
      ptr_q <= '0;
    end else if (ack_ok) begin
      ptr_q <= win_q;
    end
  end

  always_comb begin
    int start;
    found = 1'b0;
    sel   = '0;
    start = (int'(ptr_q) + 1) % NUM_SRC;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && cand[i] && (i == ((start + k) % NUM_SRC))) begin
          found = 1'b1;
          sel   = 5'(i);
        end
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        sel   = 5'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    id_d    = id_q;
    irq_d   = irq_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ASSERT;
          win_d   = sel;
          id_d    = ID_BASE5 + sel;
          irq_d   = 1'b1;
        end
      end
      ASSERT: begin
        // Masking the winner here does not withdraw the request.
        if (ack_ok) begin
          state_d = GAP;
          irq_d   = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      mask_r  <= '1;
      state_q <= IDLE;
      win_q   <= '0;
      id_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= src_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      pend_q  <= pend_d;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end
      state_q <= state_d;
      win_q   <= win_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
    end
  end

  assign mask_q    = mask_r;
  assign pending_q = pend_q;
  assign irq       = irq_q;
  assign irq_id    = id_q;

endmodule
